// File: rtl/prog_loader.sv
// Byte-serial program loader: writes a packet of 12-bit words into the RAM,
// checks the write sum against the packet checksum, then reads back and verifies.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ADDR    | waiting for base address byte (idle)
// CNT     | waiting for word count byte (0 = 256)
// DHI     | waiting for high byte of next word
// DLO     | waiting for low byte of next word
// WR      | one-cycle RAM write of the assembled word
// CKH     | waiting for checksum high byte
// CKL     | waiting for checksum low byte
// VFY     | RAM readback, one word per cycle
// DONE    | one-cycle done pulse, back to ADDR
module prog_loader (
   input  logic        clk,
   input  logic        clr,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        prog,
   output logic [7:0]  ram_a,
   output logic [11:0] ram_d,
   output logic        ram_we,
   output logic        ram_ce,
   input  logic [11:0] ram_q,
   output logic        done,
   output logic        err
);

   typedef enum logic [3:0] {
      ST_ADDR, ST_CNT, ST_DHI, ST_DLO, ST_WR, ST_CKH, ST_CKL, ST_VFY, ST_DONE
   } state_t;

   state_t      state_q;
   logic [7:0]  base_q;
   logic [8:0]  n_q;
   logic [8:0]  idx_q;
   logic [3:0]  hi_q;
   logic [11:0] sum_q;
   logic [11:0] rsum_q;
   logic        ready_q, prog_q, we_q, ce_q, done_q, err_q;
   logic [7:0]  ram_a_q;
   logic [11:0] ram_d_q;

   logic        accept_d;
   logic        last_d;
   logic [11:0] rsum_d;

   assign accept_d = in_valid & ready_q;
   assign last_d   = (idx_q + 9'd1) == n_q;
   assign rsum_d   = rsum_q + ram_q;

   assign in_ready = ready_q;
   assign prog     = prog_q;
   assign ram_a    = ram_a_q;
   assign ram_d    = ram_d_q;
   assign ram_we   = we_q;
   assign ram_ce   = ce_q;
   assign done     = done_q;
   assign err      = err_q;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= ST_ADDR;
         base_q  <= 8'h00;
         n_q     <= 9'd0;
         idx_q   <= 9'd0;
         hi_q    <= 4'h0;
         sum_q   <= 12'h000;
         rsum_q  <= 12'h000;
         ready_q <= 1'b1;
         prog_q  <= 1'b0;
         we_q    <= 1'b0;
         ce_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ram_a_q <= 8'h00;
         ram_d_q <= 12'h000;
      end else begin
         we_q   <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            ST_ADDR: if (accept_d) begin
               base_q  <= in_data;
               prog_q  <= 1'b1;
               err_q   <= 1'b0;
               state_q <= ST_CNT;
            end
            ST_CNT: if (accept_d) begin
               n_q     <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
               idx_q   <= 9'd0;
               sum_q   <= 12'h000;
               state_q <= ST_DHI;
            end
            ST_DHI: if (accept_d) begin
               hi_q <= in_data[3:0];
               if (in_data[7:4] != 4'h0) err_q <= 1'b1;
               state_q <= ST_DLO;
            end
            ST_DLO: if (accept_d) begin
               ram_a_q <= base_q + idx_q[7:0];
               ram_d_q <= {hi_q, in_data};
               we_q    <= 1'b1;
               ready_q <= 1'b0;
               state_q <= ST_WR;
            end
            ST_WR: begin
               idx_q   <= idx_q + 9'd1;
               sum_q   <= sum_q + ram_d_q;
               ready_q <= 1'b1;
               state_q <= last_d ? ST_CKH : ST_DHI;
            end
            ST_CKH: if (accept_d) begin
               hi_q <= in_data[3:0];
               if (in_data[7:4] != 4'h0) err_q <= 1'b1;
               state_q <= ST_CKL;
            end
            // sum_q is final here: the last WR edge has already passed
            ST_CKL: if (accept_d) begin
               if ({hi_q, in_data} != sum_q) err_q <= 1'b1;
               prog_q  <= 1'b0;
               ce_q    <= 1'b1;
               ram_a_q <= base_q;
               idx_q   <= 9'd0;
               rsum_q  <= 12'h000;
               ready_q <= 1'b0;
               state_q <= ST_VFY;
            end
            ST_VFY: begin
               rsum_q  <= rsum_d;
               idx_q   <= idx_q + 9'd1;
               ram_a_q <= base_q + idx_q[7:0] + 8'd1;
               if (last_d) begin
                  ce_q    <= 1'b0;
                  done_q  <= 1'b1;
                  if (rsum_d != sum_q) err_q <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               ready_q <= 1'b1;
               state_q <= ST_ADDR;
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= ST_ADDR;
            end
         endcase
      end
   end

endmodule
